captura_jogada: RTL and testbench

Parametrised move-capture datapath for the ultimate tic-tac-toe game; successor to the fixed 9-button, XOR-edge datapath. It accepts an N×N button array and captures only single-button presses. Each captured move is checked for legality against the stored occupancy of all N² micro-boards. It then holds the move pending until the control unit consumes it, and only after that updates the macro/micro selection registers and the occupancy memory.

---
 rtl/jogo_pkg.sv | 37 +++
 rtl/registrador_n.sv | 26 ++
 rtl/captura_jogada.sv | 177 +++++++++++++++++
 tb/tb_captura_jogada.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe move-capture datapath.
//   estado_t       : capture FSM states (SOLTA, AGUARDA, PENDENTE)
//   JOG_X / JOG_O  : player encodings
//   N_PADRAO       : default board side
//   is_onehot      : true when exactly one bit of the vector is set
//   onehot_to_idx  : binary index of the set bit of a one-hot vector
// Both helper functions work on a VEC_MAX-wide vector. Callers zero-extend
// their narrower vectors into that width.
package jogo_pkg;

  localparam int N_PADRAO = 3;
  localparam int VEC_MAX  = 64;

  localparam logic JOG_X = 1'b0;
  localparam logic JOG_O = 1'b1;

  typedef enum logic [1:0] {
    SOLTA    = 2'd0,
    AGUARDA  = 2'd1,
    PENDENTE = 2'd2
  } estado_t;

  function automatic logic is_onehot(input logic [VEC_MAX-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  // ORing every set position gives the exact index for a one-hot input.
  function automatic logic [5:0] onehot_to_idx(input logic [VEC_MAX-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < VEC_MAX; i++) begin
      if (v[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/registrador_n.sv
// Generic register with synchronous clear and load enable.
//   clk_i  : clock, rising edge
//   clr_i  : synchronous clear, which has priority over the enable
//   en_i   : load d_i on the next edge
//   d_i    : data in (DATA_W bits)
//   q_o    : registered data out
module registrador_n #(
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] dado_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)     dado_q <= '0;
    else if (en_i) dado_q <= d_i;
  end

  assign q_o = dado_q;

endmodule

// File: rtl/captura_jogada.sv
// Move-capture datapath for ultimate tic-tac-toe on an N x N board.
// The block captures only single-button presses and checks each move
// against the stored occupancy. It holds the move pending until the
// control unit consumes it.
//   clock, reset         : rising-edge clock and synchronous active-high reset
//   botoes[C]            : synchronised button levels, bit i = cell i
//   modo                 : 0 = macro-board selection, 1 = micro-cell move
//   jogador              : player (JOG_X / JOG_O)
//   consome              : control unit takes the pending move
//   limpa_tabuleiro      : new game (clears occupancy, macro, micro)
//   tem_jogada           : a move is pending
//   jogada_valida        : the pending move is legal
//   erro_multiplo        : one-cycle pulse when several buttons are pressed
//   indice               : index of the last captured button
//   macro, micro         : one-hot selected macro-board and last micro cell
//   leds, macro_cheio    : occupancy and full flag of the selected macro-board
//   db_estado            : FSM state
module captura_jogada
  import jogo_pkg::*;
#(
  parameter  int N  = N_PADRAO,
  localparam int C  = N * N,
  localparam int IW = $clog2(C)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [C-1:0]  botoes,
  input  logic          modo,
  input  logic          jogador,
  input  logic          consome,
  input  logic          limpa_tabuleiro,
  output logic          tem_jogada,
  output logic          jogada_valida,
  output logic          erro_multiplo,
  output logic [IW-1:0] indice,
  output logic [C-1:0]  macro,
  output logic [C-1:0]  micro,
  output logic [C-1:0]  leds,
  output logic          macro_cheio,
  output logic [1:0]    db_estado
);

  localparam int OW = $clog2(C * C);

  estado_t        estado_q, estado_d;
  logic           captura, erro_d, erro_q;
  logic           grava_macro, grava_micro, limpa_regs;
  logic [IW-1:0]  indice_q, macro_idx;
  logic           modo_q, jogador_q;
  logic [C-1:0]   macro_q, micro_q;
  logic [C*C-1:0] occ_x_q, occ_o_q, occ_x_d, occ_o_d;
  logic [C-1:0]   ocup_tab [C];
  logic [OW-1:0]  pos_w;
  logic           macro_sel, valida;

  assign limpa_regs = reset | limpa_tabuleiro;

  // Latched fields of the pending move: index, mode and player.
  registrador_n #(.DATA_W(IW + 2)) u_campos (
    .clk_i (clock),
    .clr_i (reset),
    .en_i  (captura),
    .d_i   ({IW'(onehot_to_idx(VEC_MAX'(botoes))), modo, jogador}),
    .q_o   ({indice_q, modo_q, jogador_q})
  );

  registrador_n #(.DATA_W(C)) u_macro (
    .clk_i (clock),
    .clr_i (limpa_regs),
    .en_i  (grava_macro),
    .d_i   (C'(1) << indice_q),
    .q_o   (macro_q)
  );

  registrador_n #(.DATA_W(C)) u_micro (
    .clk_i (clock),
    .clr_i (limpa_regs),
    .en_i  (grava_micro),
    .d_i   (C'(1) << indice_q),
    .q_o   (micro_q)
  );

  // Combined X|O occupancy viewed one macro-board at a time.
  for (genvar b = 0; b < C; b++) begin : g_tab
    assign ocup_tab[b] = occ_x_q[b*C +: C] | occ_o_q[b*C +: C];
  end

  assign macro_sel = |macro_q;
  assign macro_idx = IW'(onehot_to_idx(VEC_MAX'(macro_q)));

  // A macro selection is legal when the target board still has a free cell.
  // A micro move is legal when a board is selected and the cell is free.
  assign valida = modo_q ? (macro_sel && !ocup_tab[macro_idx][indice_q])
                         : !(&ocup_tab[indice_q]);

  always_comb begin
    estado_d    = estado_q;
    captura     = 1'b0;
    erro_d      = 1'b0;
    grava_macro = 1'b0;
    grava_micro = 1'b0;
    unique case (estado_q)
      SOLTA: begin
        // The FSM re-arms only after a fully released cycle, so a button held
        // through reset, clear or a previous capture is never taken twice.
        if (botoes == '0) estado_d = AGUARDA;
      end
      AGUARDA: begin
        if (is_onehot(VEC_MAX'(botoes))) begin
          captura  = 1'b1;
          estado_d = PENDENTE;
        end else if (botoes != '0) begin
          erro_d   = 1'b1;
          estado_d = SOLTA;
        end
      end
      PENDENTE: begin
        if (consome) begin
          grava_macro = valida & ~modo_q;
          grava_micro = valida & modo_q;
          estado_d    = SOLTA;
        end
      end
      default: estado_d = SOLTA;
    endcase
    // A new game cancels any capture or write in the same cycle.
    if (limpa_tabuleiro) begin
      estado_d    = SOLTA;
      captura     = 1'b0;
      erro_d      = 1'b0;
      grava_macro = 1'b0;
      grava_micro = 1'b0;
    end
  end

  assign pos_w = OW'(macro_idx) * OW'(C) + OW'(indice_q);

  always_comb begin
    occ_x_d = occ_x_q;
    occ_o_d = occ_o_q;
    if (grava_micro) begin
      if (jogador_q == JOG_O) occ_o_d[pos_w] = 1'b1;
      else                    occ_x_d[pos_w] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= SOLTA;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      erro_q   <= erro_d;
    end
  end

  always_ff @(posedge clock) begin
    if (limpa_regs) begin
      occ_x_q <= '0;
      occ_o_q <= '0;
    end else begin
      occ_x_q <= occ_x_d;
      occ_o_q <= occ_o_d;
    end
  end

  assign tem_jogada    = (estado_q == PENDENTE);
  assign jogada_valida = tem_jogada & valida;
  assign erro_multiplo = erro_q;
  assign indice        = indice_q;
  assign macro         = macro_q;
  assign micro         = micro_q;
  assign leds          = macro_sel ? ocup_tab[macro_idx] : '0;
  assign macro_cheio   = macro_sel & (&leds);
  assign db_estado     = 2'(estado_q);

endmodule

// File: tb/tb_captura_jogada.sv
module tb_captura_jogada;

  logic       clock = 1'b0;
  logic       reset, modo, jogador, consome, limpa_tabuleiro;
  logic [8:0] botoes;
  logic       tem_jogada, jogada_valida, erro_multiplo, macro_cheio;
  logic [3:0] indice;
  logic [8:0] macro, micro, leds;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;

  // Reference model: the board contents, the selections and the pending move.
  int occm [9][9];   // 0 = empty, 1 = X, 2 = O
  int msel, mic;     // -1 means nothing selected
  int p_idx, p_modo, p_jog, last_idx;
  bit pend, armed, m_err;

  captura_jogada #(.N(3)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .modo(modo),
    .jogador(jogador), .consome(consome), .limpa_tabuleiro(limpa_tabuleiro),
    .tem_jogada(tem_jogada), .jogada_valida(jogada_valida),
    .erro_multiplo(erro_multiplo), .indice(indice), .macro(macro),
    .micro(micro), .leds(leds), .macro_cheio(macro_cheio),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int popcnt(input logic [8:0] v);
    int c = 0;
    for (int i = 0; i < 9; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int first_bit(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int ocupadas(input int b);
    int c = 0;
    for (int i = 0; i < 9; i++) if (occm[b][i] != 0) c++;
    return c;
  endfunction

  function automatic bit legal();
    if (p_modo == 0) return ocupadas(p_idx) < 9;
    if (msel < 0) return 1'b0;
    return occm[msel][p_idx] == 0;
  endfunction

  function automatic logic [8:0] exp_leds();
    logic [8:0] v = '0;
    if (msel >= 0)
      for (int i = 0; i < 9; i++) if (occm[msel][i] != 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic limpa_modelo();
    for (int b = 0; b < 9; b++)
      for (int i = 0; i < 9; i++) occm[b][i] = 0;
    msel = -1; mic = -1; pend = 0; armed = 0;
  endtask

  // Apply the game rules to the inputs present at the coming edge.
  task automatic modelo();
    m_err = 0;
    if (reset) begin
      limpa_modelo();
      last_idx = 0; p_idx = 0; p_modo = 0; p_jog = 0;
    end else if (limpa_tabuleiro) begin
      limpa_modelo();
    end else if (pend) begin
      if (consome) begin
        if (legal()) begin
          if (p_modo == 0) msel = p_idx;
          else begin
            mic = p_idx;
            occm[msel][p_idx] = p_jog + 1;
          end
        end
        pend = 0; armed = 0;
      end
    end else if (!armed) begin
      armed = (botoes == 0);
    end else if (botoes != 0) begin
      if (popcnt(botoes) == 1) begin
        pend = 1; p_idx = first_bit(botoes); p_modo = int'(modo);
        p_jog = int'(jogador); last_idx = p_idx;
      end else begin
        m_err = 1; armed = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    logic [8:0] lv;
    modelo();
    @(posedge clock);
    #1;
    lv = exp_leds();
    chk({tag, ".tem"},    32'(tem_jogada),    32'(pend));
    chk({tag, ".valida"}, 32'(jogada_valida), 32'(pend && legal()));
    chk({tag, ".erro"},   32'(erro_multiplo), 32'(m_err));
    chk({tag, ".indice"}, 32'(indice),        32'(last_idx));
    chk({tag, ".macro"},  32'(macro),         (msel >= 0) ? (32'd1 << msel) : 32'd0);
    chk({tag, ".micro"},  32'(micro),         (mic >= 0) ? (32'd1 << mic) : 32'd0);
    chk({tag, ".leds"},   32'(leds),          32'(lv));
    chk({tag, ".cheio"},  32'(macro_cheio),   32'((msel >= 0) && (lv == 9'h1FF)));
    chk({tag, ".estado"}, 32'(db_estado),     pend ? 32'd2 : (armed ? 32'd1 : 32'd0));
  endtask

  task automatic pressiona(input logic [8:0] b, input logic m, input logic j);
    botoes = '0;
    tick("solta");
    botoes = b; modo = m; jogador = j;
    tick("press");
    botoes = '0;
  endtask

  task automatic consumir();
    consome = 1'b1;
    tick("consome");
    consome = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; botoes = 9'h010; modo = 1'b0; jogador = 1'b0;
    consome = 1'b0; limpa_tabuleiro = 1'b0;
    limpa_modelo();
    last_idx = 0; p_idx = 0; p_modo = 0; p_jog = 0;

    // Button held through reset is not captured.
    tick("rst"); tick("rst");
    reset = 1'b0;
    tick("held"); tick("held");
    chk("held_no_capture", 32'(tem_jogada), 32'd0);
    botoes = '0;
    tick("release");
    botoes = 9'h004;
    tick("press004");
    chk("tp_tem", 32'(tem_jogada), 32'd1);
    chk("tp_indice", 32'(indice), 32'd2);
    botoes = '0;
    consumir();

    // Macro selection, then a micro move by X.
    pressiona(9'h001, 1'b0, 1'b0); consumir();
    chk("tp_macro", 32'(macro), 32'h001);
    pressiona(9'h010, 1'b1, 1'b0); consumir();
    chk("tp_micro", 32'(micro), 32'h010);
    chk("tp_leds", 32'(leds), 32'h010);

    // Same cell by O is illegal and changes nothing.
    pressiona(9'h010, 1'b1, 1'b1);
    chk("tp_repeat_invalid", 32'(jogada_valida), 32'd0);
    consumir();
    chk("tp_repeat_leds", 32'(leds), 32'h010);

    // Two buttons at once.
    botoes = '0; tick("arm");
    botoes = 9'h003; tick("multi");
    chk("tp_erro_pulse", 32'(erro_multiplo), 32'd1);
    chk("tp_erro_tem", 32'(tem_jogada), 32'd0);
    tick("multi_hold");
    chk("tp_erro_end", 32'(erro_multiplo), 32'd0);
    chk("tp_erro_solta", 32'(db_estado), 32'd0);
    botoes = '0; tick("multi_release");

    // Fill macro-board 0.
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        pressiona(9'(1 << i), 1'b1, 1'(i % 2));
        consumir();
      end
    end
    chk("tp_cheio", 32'(macro_cheio), 32'd1);
    chk("tp_leds_full", 32'(leds), 32'h1FF);
    pressiona(9'h001, 1'b0, 1'b0);
    chk("tp_full_target", 32'(jogada_valida), 32'd0);
    consumir();
    pressiona(9'h002, 1'b0, 1'b0);
    chk("tp_free_target", 32'(jogada_valida), 32'd1);

    // Clear overrides consume in the same cycle.
    limpa_tabuleiro = 1'b1; consome = 1'b1;
    tick("limpa");
    limpa_tabuleiro = 1'b0; consome = 1'b0;
    chk("tp_limpa_macro", 32'(macro), 32'd0);
    chk("tp_limpa_leds", 32'(leds), 32'd0);
    chk("tp_limpa_estado", 32'(db_estado), 32'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      botoes = '0;
      else if (r < 85) botoes = 9'(1 << $urandom_range(0, 8));
      else             botoes = 9'($urandom_range(0, 511));
      modo            = 1'($urandom_range(0, 1));
      jogador         = 1'($urandom_range(0, 1));
      consome         = ($urandom_range(0, 99) < 40);
      limpa_tabuleiro = ($urandom_range(0, 99) < 2);
      reset           = ($urandom_range(0, 299) == 0);
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
